direction_scheduler: RTL and testbench

DIRECTION_SCHEDULER -- requirements
Module: direction_scheduler

---
 rtl/snake_pkg.sv | 33 +++
 rtl/dir_fifo.sv | 74 +++++++
 rtl/direction_scheduler.sv | 175 +++++++++++++++++
 tb/tb_direction_scheduler.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake direction scheduler.
// Contents:
//   - one-hot direction constants (STOP/UP/DOWN/LEFT/RIGHT)
//   - state_t : scheduler FSM encoding (IDLE/RUN/PAUSE/DEAD)
//   - reverse_dir() : opposite direction of a one-hot direction
package snake_pkg;

  localparam logic [4:0] DIR_STOP  = 5'b00001;
  localparam logic [4:0] DIR_UP    = 5'b00010;
  localparam logic [4:0] DIR_DOWN  = 5'b00100;
  localparam logic [4:0] DIR_LEFT  = 5'b01000;
  localparam logic [4:0] DIR_RIGHT = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DEAD  = 2'd3
  } state_t;

  // STOP has no opposite; it maps to itself, so nothing a button can
  // produce is ever rejected as "reverse of STOP".
  function automatic logic [4:0] reverse_dir(input logic [4:0] d);
    case (d)
      DIR_UP:    reverse_dir = DIR_DOWN;
      DIR_DOWN:  reverse_dir = DIR_UP;
      DIR_LEFT:  reverse_dir = DIR_RIGHT;
      DIR_RIGHT: reverse_dir = DIR_LEFT;
      default:   reverse_dir = DIR_STOP;
    endcase
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small direction request queue (DEPTH entries x 5 bits), shift-register style.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : synchronous clear, wins over push/pop
//   push, din    : enqueue strobe and data (ignored when full)
//   pop          : dequeue strobe (ignored when empty)
//   head, tail   : oldest / newest entry (don't-care when empty)
//   count        : number of valid entries, 0..DEPTH
// Handshake: push and pop are single-cycle strobes with no back-pressure;
// the caller reads count to know whether a strobe will take effect, and
// the queue silently ignores a push when full or a pop when empty.
// Push and pop in the same cycle both apply: the pre-push head leaves and
// the new entry lands at the tail, count unchanged.
module dir_fifo
  import snake_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [4:0]    din,
  input  logic          pop,
  output logic [4:0]    head,
  output logic [4:0]    tail,
  output logic [CW-1:0] count
);

  logic [4:0] mem     [DEPTH];
  logic [4:0] shifted [DEPTH];
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && (count < CW'(DEPTH));
  assign head    = mem[0];

  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) shifted[i] = mem[i + 1];
    shifted[DEPTH-1] = mem[DEPTH-1];
  end

  always_comb begin
    tail = DIR_STOP;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i + 1) == count) tail = mem[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= DIR_STOP;
    end else if (flush) begin
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_pop) begin
          // Everything moves one slot toward the head; a simultaneous push
          // lands in the slot the old tail vacates.
          if (do_push && (CW'(i + 1) == count)) mem[i] <= din;
          else                                  mem[i] <= shifted[i];
        end else if (do_push && (CW'(i) == count)) begin
          mem[i] <= din;
        end
      end
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/direction_scheduler.sv
// Snake game direction scheduler.
// Turns debounced button levels into queued direction requests and applies
// one queued request per game step. Also owns the game step tick and the
// IDLE/RUN/PAUSE/DEAD game state.
// Ports:
//   in_clk, in_reset_n      : clock, asynchronous active-low reset
//   in_button_{up,down,left,right} : debounced button levels
//   in_button_reset         : synchronous game restart level (overrides all)
//   in_pause                : pause toggle level (rising edge toggles)
//   in_collision            : one-cycle collision pulse from game core
//   out_direction           : one-hot applied direction
//   out_step                : one-cycle pulse per game step
//   out_state               : FSM state (0 IDLE, 1 RUN, 2 PAUSE, 3 DEAD)
//   out_queue_count         : number of queued requests
module direction_scheduler
  import snake_pkg::*;
#(
  parameter int TICK_DIV    = 4_000_000,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic       in_clk,
  input  logic       in_reset_n,
  input  logic       in_button_up,
  input  logic       in_button_down,
  input  logic       in_button_left,
  input  logic       in_button_right,
  input  logic       in_button_reset,
  input  logic       in_pause,
  input  logic       in_collision,
  output logic [4:0] out_direction,
  output logic       out_step,
  output logic [1:0] out_state,
  output logic [1:0] out_queue_count
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int QC_W  = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  state_t           state, state_n;
  logic [4:0]       dir, dir_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       btn_q;
  logic             pause_q;
  // Cleared by reset; the first cycle after reset only samples the buttons,
  // so a button held through reset must be released before it counts.
  logic             primed;

  logic [3:0]       btn_now, btn_rise;
  logic             pause_rise;
  logic             req_valid, req_ok;
  logic [4:0]       req, ref_dir;
  logic             wrap;
  logic             q_push, q_pop, q_flush;
  logic [4:0]       q_head, q_tail;
  logic [QC_W-1:0]  q_count;

  assign btn_now    = {in_button_right, in_button_left, in_button_down, in_button_up};
  assign btn_rise   = btn_now & ~btn_q & {4{primed}};
  assign pause_rise = in_pause & ~pause_q & primed;

  // One request per cycle, priority UP > DOWN > LEFT > RIGHT.
  always_comb begin
    req       = DIR_STOP;
    req_valid = 1'b1;
    if      (btn_rise[0]) req = DIR_UP;
    else if (btn_rise[1]) req = DIR_DOWN;
    else if (btn_rise[2]) req = DIR_LEFT;
    else if (btn_rise[3]) req = DIR_RIGHT;
    else                  req_valid = 1'b0;
  end

  // Validate against what the snake will be doing when this request is
  // applied: the newest queued request if any, else the current direction.
  assign ref_dir = (q_count != '0) ? q_tail : dir;
  assign req_ok  = req_valid && (req != ref_dir) && (req != reverse_dir(ref_dir));

  assign wrap = (state == ST_RUN) && (cnt == CNT_LAST);

  always_comb begin
    state_n = state;
    dir_n   = dir;
    cnt_n   = cnt;
    q_push  = 1'b0;
    q_pop   = 1'b0;
    q_flush = 1'b0;
    if (in_button_reset) begin
      state_n = ST_IDLE;
      dir_n   = DIR_STOP;
      cnt_n   = '0;
      q_flush = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_n = '0;
          dir_n = DIR_STOP;
          // First move is applied immediately so the game starts at once.
          if (req_ok) begin
            dir_n   = req;
            q_flush = 1'b1;
            state_n = ST_RUN;
          end
        end
        ST_RUN: begin
          cnt_n = wrap ? '0 : cnt + 1'b1;
          if (in_collision) begin
            state_n = ST_DEAD;
            dir_n   = DIR_STOP;
            cnt_n   = '0;
            q_flush = 1'b1;
          end else begin
            if (wrap && (q_count != '0)) begin
              q_pop = 1'b1;
              dir_n = q_head;
            end
            q_push = req_ok;
            if (pause_rise) state_n = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (in_collision) begin
            state_n = ST_DEAD;
            dir_n   = DIR_STOP;
            cnt_n   = '0;
            q_flush = 1'b1;
          end else begin
            q_push = req_ok;
            if (pause_rise) state_n = ST_RUN;
          end
        end
        default: begin
          cnt_n = '0;
          dir_n = DIR_STOP;
        end
      endcase
    end
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state   <= ST_IDLE;
      dir     <= DIR_STOP;
      cnt     <= '0;
      btn_q   <= '0;
      pause_q <= 1'b0;
      primed  <= 1'b0;
    end else begin
      state   <= state_n;
      dir     <= dir_n;
      cnt     <= cnt_n;
      btn_q   <= btn_now;
      pause_q <= in_pause;
      primed  <= 1'b1;
    end
  end

  dir_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk   (in_clk),
    .rst_n (in_reset_n),
    .flush (q_flush),
    .push  (q_push),
    .din   (req),
    .pop   (q_pop),
    .head  (q_head),
    .tail  (q_tail),
    .count (q_count)
  );

  // The step pulse survives a coincident collision but not a restart.
  assign out_step        = wrap && !in_button_reset;
  assign out_direction   = dir;
  assign out_state       = state;
  assign out_queue_count = 2'(q_count);

endmodule

// File: tb/tb_direction_scheduler.sv
// Directed self-checking bench for direction_scheduler with TICK_DIV = 4,
// QUEUE_DEPTH = 2. Inputs change 1 ns after a rising edge; outputs are
// sampled at that same point, well away from the next edge.
module tb_direction_scheduler;

  localparam logic [4:0] D_STOP  = 5'b00001;
  localparam logic [4:0] D_UP    = 5'b00010;
  localparam logic [4:0] D_DOWN  = 5'b00100;
  localparam logic [4:0] D_LEFT  = 5'b01000;
  localparam logic [4:0] D_RIGHT = 5'b10000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       up, down, left, right, breset, pause, coll;
  logic [4:0] direction;
  logic       step;
  logic [1:0] state;
  logic [1:0] qcount;

  int checks = 0;
  int errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  direction_scheduler #(.TICK_DIV(4), .QUEUE_DEPTH(2)) dut (
    .in_clk          (clk),
    .in_reset_n      (rst_n),
    .in_button_up    (up),
    .in_button_down  (down),
    .in_button_left  (left),
    .in_button_right (right),
    .in_button_reset (breset),
    .in_pause        (pause),
    .in_collision    (coll),
    .out_direction   (direction),
    .out_step        (step),
    .out_state       (state),
    .out_queue_count (qcount)
  );

  // driver tasks
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; up = 0; down = 0; left = 0; breset = 0; pause = 0; coll = 0;
    right = 1'b1;  // held through reset: must not start the game
    tick(2);
    check("rst_state", state, 2'd0);
    check("rst_dir", direction, D_STOP);
    check("rst_step", step, 1'b0);
    check("rst_qcount", qcount, 2'd0);

    rst_n = 1'b1;
    tick(3);
    check("held_btn_idle", state, 2'd0);
    check("held_btn_dir", direction, D_STOP);
    right = 0;
    tick();

    // Start: RIGHT applied directly, counter = 0
    right = 1;
    tick();
    check("start_dir", direction, D_RIGHT);
    check("start_state", state, 2'd1);
    check("start_step_c0", step, 1'b0);
    right = 0;
    tick();  check("step_c1", step, 1'b0);
    tick();  check("step_c2", step, 1'b0);
    tick();  check("step_c3", step, 1'b1);
    tick();  check("step_c0b", step, 1'b0);
    tick(2); check("step_c2b", step, 1'b0);
    tick();  check("step_c3b", step, 1'b1);

    // Reverse request while moving RIGHT is dropped (counter at 3 here)
    left = 1;
    tick();  // counter 0
    check("rev_qcount", qcount, 2'd0);
    left = 0;
    tick(4);  // through another step boundary
    check("rev_dir", direction, D_RIGHT);

    // UP, LEFT, DOWN within one step; counter 0 now
    up = 1;
    tick();  // counter 1
    check("q_up_count", qcount, 2'd1);
    check("q_up_latency", direction, D_RIGHT);
    up = 0; left = 1;
    tick();  // counter 2
    check("q_left_count", qcount, 2'd2);
    left = 0; down = 1;
    tick();  // counter 3, DOWN dropped because full
    check("q_full_count", qcount, 2'd2);
    check("q_full_step", step, 1'b1);
    down = 0;
    tick();  // counter 0, pop UP
    check("pop1_dir", direction, D_UP);
    check("pop1_count", qcount, 2'd1);
    tick(4);
    check("pop2_dir", direction, D_LEFT);
    check("pop2_count", qcount, 2'd0);
    tick(4);
    check("no_down_dir", direction, D_LEFT);

    // UP and LEFT together: only UP queued (counter 0)
    up = 1; left = 1;
    tick();  // counter 1
    check("prio_count", qcount, 2'd1);
    up = 0; left = 0;
    tick(3);  // counter 0 after pop
    check("prio_dir", direction, D_UP);
    check("prio_count0", qcount, 2'd0);

    // Pause at counter 1: counter advances to 2 on the pausing edge
    tick();  // counter 1
    pause = 1;
    tick();  // counter 2, PAUSE
    check("pause_state", state, 2'd2);
    for (int i = 0; i < 5; i++) begin
      check("pause_no_step", step, 1'b0);
      tick();
    end
    pause = 0; right = 1;  // request accepted while paused
    tick();
    check("pause_push", qcount, 2'd1);
    check("pause_dir", direction, D_UP);
    right = 0; pause = 1;
    tick();  // back to RUN, counter still 2
    check("resume_state", state, 2'd1);
    check("resume_step0", step, 1'b0);
    tick();  // counter 3
    check("resume_step1", step, 1'b1);
    pause = 0;
    tick();  // pop RIGHT
    check("resume_pop_dir", direction, D_RIGHT);
    check("resume_pop_cnt", qcount, 2'd0);

    // Collision on a step boundary (counter 0 now)
    up = 1;
    tick();  // counter 1, UP queued
    up = 0;
    tick(2);  // counter 3
    check("coll_step", step, 1'b1);
    coll = 1;
    #1;
    check("coll_step_kept", step, 1'b1);
    tick();
    coll = 0;
    check("dead_state", state, 2'd3);
    check("dead_dir", direction, D_STOP);
    check("dead_qcount", qcount, 2'd0);
    check("dead_step", step, 1'b0);
    down = 1;
    tick();
    down = 0;
    check("dead_ignore_dir", direction, D_STOP);
    check("dead_ignore_q", qcount, 2'd0);
    check("dead_ignore_st", state, 2'd3);

    breset = 1;
    tick();
    breset = 0;
    check("restart_state", state, 2'd0);
    check("restart_dir", direction, D_STOP);
    left = 1;
    tick();
    left = 0;
    check("restart_start_dir", direction, D_LEFT);
    check("restart_start_st", state, 2'd1);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
